// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: bridge FSM state encoding and bus size codes.
// Also used by the instruction-side bridge.
package mem_bus_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned SIZE_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ADDR = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_DONE      = 2'd3
  } mem_state_e;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/addr_map.sv
// Combinational virtual-to-physical data address mapping.
// kseg0/kseg1 (top two bits 2'b10) drop to physical by clearing the top three
// bits; every other address passes through unchanged.
//   vaddr_i  virtual byte address
//   paddr_o  physical byte address
module addr_map #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] vaddr_i,
  output logic [ADDR_W-1:0] paddr_o
);

  localparam int unsigned CLR_W = 3;

  always_comb begin
    paddr_o = vaddr_i;
    if (vaddr_i[ADDR_W-1 -: 2] == 2'b10) begin
      paddr_o = {CLR_W'(0), vaddr_i[ADDR_W-CLR_W-1:0]};
    end
  end

endmodule

// File: rtl/data_sram_bridge.sv
// Memory-stage bridge from the pipeline M stage to an SRAM-like data bus with
// addr_ok/data_ok handshakes. One outstanding transaction at a time; the
// pipeline is held with mem_stall until the access completes.
// Optional build macro: DATA_ADDR_MAP_EN (kseg0/kseg1 address mapping via
// addr_map ahead of the address register).
//   clk, rst            clock, synchronous active-low reset
//   mem_*M              M-stage request fields; mem_rdataM returns load data
//   pipe_stall          other stall sources holding M
//   mem_stall           combinational pipeline freeze
//   data_*              bus request side (registered) and response side
module data_sram_bridge
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_reqM,
  input  logic                  mem_wrM,
  input  logic [SIZE_W-1:0]     mem_sizeM,
  input  logic [DATA_W/8-1:0]   mem_wstrbM,
  input  logic [ADDR_W-1:0]     mem_addrM,
  input  logic [DATA_W-1:0]     mem_wdataM,
  input  logic                  pipe_stall,
  output logic [DATA_W-1:0]     mem_rdataM,
  output logic                  mem_stall,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [SIZE_W-1:0]     data_size,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W/8-1:0]   data_wstrb,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_W-1:0]     data_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  mem_state_e          state_q, state_d;
  logic                wr_q, wr_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_phys;

  // Address translation sits in front of the address register.
`ifdef DATA_ADDR_MAP_EN
  addr_map #(
    .ADDR_W (ADDR_W)
  ) u_addr_map (
    .vaddr_i (mem_addrM),
    .paddr_o (addr_phys)
  );
`else
  assign addr_phys = mem_addrM;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields and returned load data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      size_q  <= size_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_reqM) begin
          state_d = ST_WAIT_ADDR;
          wr_d    = mem_wrM;
          size_d  = mem_sizeM;
          wstrb_d = mem_wrM ? mem_wstrbM : '0;
          addr_d  = addr_phys;
          wdata_d = mem_wdataM;
        end
      end
      ST_WAIT_ADDR: begin
        if (data_addr_ok) begin
          // A slave may return data in the same cycle it accepts the address.
          if (data_data_ok) begin
            state_d = ST_DONE;
            if (!wr_q) begin
              rdata_d = data_rdata;
            end
          end else begin
            state_d = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (data_data_ok) begin
          state_d = ST_DONE;
          if (!wr_q) begin
            rdata_d = data_rdata;
          end
        end
      end
      ST_DONE: begin
        // Same instruction still in M while pipe_stall holds; do not reissue.
        if (!pipe_stall) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_req   = (state_q == ST_WAIT_ADDR);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wstrb = wstrb_q;
  assign data_wdata = wdata_q;
  assign mem_rdataM = rdata_q;

  // Stalls already in IDLE when a request shows up.
  assign mem_stall  = mem_reqM & (state_q != ST_DONE);

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: directed vector table, random
// transactions against a transaction-level reference, and reset corner case.
module tb_data_sram_bridge;
  import mem_bus_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_reqM;
  logic        mem_wrM;
  logic [1:0]  mem_sizeM;
  logic [3:0]  mem_wstrbM;
  logic [31:0] mem_addrM;
  logic [31:0] mem_wdataM;
  logic        pipe_stall;
  logic [31:0] mem_rdataM;
  logic        mem_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_reqM     (mem_reqM),
    .mem_wrM      (mem_wrM),
    .mem_sizeM    (mem_sizeM),
    .mem_wstrbM   (mem_wstrbM),
    .mem_addrM    (mem_addrM),
    .mem_wdataM   (mem_wdataM),
    .pipe_stall   (pipe_stall),
    .mem_rdataM   (mem_rdataM),
    .mem_stall    (mem_stall),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          a_dly;
    int          d_dly;
    logic        same;
    int          pstall;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    int          exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cur_rdata = 32'h0;
  vec_t        vecs[6];

`ifdef DATA_ADDR_MAP_EN
  localparam logic [31:0] EXP_BFC = 32'h1FC0_0100;
  localparam logic [31:0] EXP_K0  = 32'h0000_0004;
`else
  localparam logic [31:0] EXP_BFC = 32'hBFC0_0100;
  localparam logic [31:0] EXP_K0  = 32'h8000_0004;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Physical address the bus should see for a given virtual address.
  function automatic logic [31:0] map_ref(input logic [31:0] a);
    logic [31:0] r;
    r = a;
`ifdef DATA_ADDR_MAP_EN
    if (a >= 32'h8000_0000 && a < 32'hC000_0000) r = a & 32'h1FFF_FFFF;
`endif
    return r;
  endfunction

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic [3:0] strb,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int a, input int d,
                              input logic same, input int p, input logic [31:0] ea,
                              input logic [3:0] ew, input int es, input logic [31:0] er);
    vec_t v;
    v.wr = wr; v.size = size; v.strb = strb; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.a_dly = a; v.d_dly = d; v.same = same; v.pstall = p;
    v.exp_addr = ea; v.exp_wstrb = ew; v.exp_stall = es; v.exp_rdata = er;
    return v;
  endfunction

  // One complete access: request cycle, address phase, data phase, DONE hold.
  task automatic run_txn(input vec_t v);
    int seen;
    seen = 0;
    @(negedge clk);
    mem_reqM = 1'b1; mem_wrM = v.wr; mem_sizeM = v.size; mem_wstrbM = v.strb;
    mem_addrM = v.addr; mem_wdataM = v.wdata; pipe_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
    #1;
    chk("c0_stall", 32'(mem_stall), 32'd1);
    chk("c0_req", 32'(data_req), 32'd0);
    chk("c0_rdata", mem_rdataM, cur_rdata);
    if (mem_stall) seen++;
    for (int i = 0; i <= v.a_dly; i++) begin
      @(negedge clk);
      data_addr_ok = (i == v.a_dly);
      data_data_ok = (i == v.a_dly) && v.same;
      data_rdata   = ((i == v.a_dly) && v.same) ? v.rdata : $urandom;
      pipe_stall   = 1'($urandom_range(1, 0));
      #1;
      chk("wa_req", 32'(data_req), 32'd1);
      chk("wa_wr", 32'(data_wr), 32'(v.wr));
      chk("wa_size", 32'(data_size), 32'(v.size));
      chk("wa_addr", data_addr, v.exp_addr);
      chk("wa_wstrb", 32'(data_wstrb), 32'(v.exp_wstrb));
      chk("wa_wdata", data_wdata, v.wdata);
      if (mem_stall) seen++;
    end
    if (!v.same) begin
      for (int i = 0; i <= v.d_dly; i++) begin
        @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = (i == v.d_dly);
        data_rdata   = (i == v.d_dly) ? v.rdata : $urandom;
        pipe_stall   = 1'($urandom_range(1, 0));
        #1;
        chk("wd_req", 32'(data_req), 32'd0);
        if (mem_stall) seen++;
      end
    end
    cur_rdata = v.exp_rdata;
    for (int i = 0; i <= v.pstall; i++) begin
      @(negedge clk);
      data_addr_ok = 1'b0;
      // Stray data_ok while parked in DONE must be ignored.
      data_data_ok = (i == 0) && (v.pstall > 0);
      data_rdata   = $urandom;
      pipe_stall   = (i < v.pstall);
      #1;
      chk("done_stall", 32'(mem_stall), 32'd0);
      chk("done_req", 32'(data_req), 32'd0);
      chk("done_rdata", mem_rdataM, cur_rdata);
      if (mem_stall) seen++;
    end
    chk("stall_cycles", 32'(seen), 32'(v.exp_stall));
  endtask

  task automatic idle_cycle(input logic viol);
    @(negedge clk);
    mem_reqM = 1'b0; pipe_stall = 1'b0;
    data_addr_ok = viol; data_data_ok = viol; data_rdata = $urandom;
    #1;
    chk("idle_stall", 32'(mem_stall), 32'd0);
    chk("idle_req", 32'(data_req), 32'd0);
    chk("idle_rdata", mem_rdataM, cur_rdata);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_wr", 32'(data_wr), 32'd0);
    chk("rst_size", 32'(data_size), 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wstrb", 32'(data_wstrb), 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_rdata", mem_rdataM, 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
  endtask

  initial begin
    vec_t rv;
    rst = 1'b0; mem_reqM = 1'b0; mem_wrM = 1'b0; mem_sizeM = '0; mem_wstrbM = '0;
    mem_addrM = '0; mem_wdataM = '0; pipe_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;

    //         wr    size       strb     addr          wdata         rdata         a  d  same p  exp_addr      wstrb    stall exp_rdata
    vecs[0] = mk(1'b0, SIZE_WORD, 4'hF,  32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 0, 0, 1'b0, 0, 32'h0000_0010, 4'h0,    3, 32'hDEAD_BEEF);
    vecs[1] = mk(1'b1, SIZE_BYTE, 4'b0100, 32'h0000_0022, 32'h00AB_0000, 32'h5555_5555, 3, 0, 1'b0, 0, 32'h0000_0022, 4'b0100, 6, 32'hDEAD_BEEF);
    vecs[2] = mk(1'b0, SIZE_HALF, 4'h3,  32'h0000_0040, 32'h0,        32'h0000_CAFE, 0, 1, 1'b0, 2, 32'h0000_0040, 4'h0,    4, 32'h0000_CAFE);
    vecs[3] = mk(1'b0, SIZE_WORD, 4'h0,  32'h0000_0080, 32'h0,        32'h1234_5678, 0, 0, 1'b1, 0, 32'h0000_0080, 4'h0,    2, 32'h1234_5678);
    vecs[4] = mk(1'b0, SIZE_WORD, 4'hF,  32'hBFC0_0100, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 1, 2, 1'b0, 0, EXP_BFC,       4'h0,    6, 32'hA5A5_5A5A);
    vecs[5] = mk(1'b1, SIZE_WORD, 4'hF,  32'h8000_0004, 32'h1122_3344, 32'h0BAD_0BAD, 2, 0, 1'b1, 1, EXP_K0,        4'hF,    4, 32'hA5A5_5A5A);

    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors; alternate back-to-back and separated issue.
    for (int k = 0; k < 6; k++) begin
      run_txn(vecs[k]);
      if (k % 2 == 1) idle_cycle(1'b1);
    end
    idle_cycle(1'b0);

    // Randomised transactions against the transaction-level reference.
    for (int k = 0; k < 40; k++) begin
      rv.wr     = 1'($urandom_range(1, 0));
      rv.size   = 2'($urandom_range(2, 0));
      rv.strb   = 4'($urandom);
      rv.addr   = $urandom;
      rv.wdata  = $urandom;
      rv.rdata  = $urandom;
      rv.a_dly  = $urandom_range(3, 0);
      rv.d_dly  = $urandom_range(3, 0);
      rv.same   = 1'($urandom_range(1, 0));
      rv.pstall = $urandom_range(2, 0);
      rv.exp_addr  = map_ref(rv.addr);
      rv.exp_wstrb = rv.wr ? rv.strb : 4'h0;
      rv.exp_stall = 2 + rv.a_dly + (rv.same ? 0 : rv.d_dly + 1);
      rv.exp_rdata = rv.wr ? cur_rdata : rv.rdata;
      run_txn(rv);
      if ($urandom_range(1, 0) == 1) idle_cycle(1'($urandom_range(1, 0)));
    end

    // Reset while waiting for load data abandons the access.
    idle_cycle(1'b0);
    @(negedge clk);
    mem_reqM = 1'b1; mem_wrM = 1'b0; mem_sizeM = SIZE_WORD; mem_wstrbM = 4'hF;
    mem_addrM = 32'h0000_0100; mem_wdataM = 32'hCCCC_CCCC;
    @(negedge clk);
    data_addr_ok = 1'b1;
    #1;
    chk("rw_req", 32'(data_req), 32'd1);
    @(negedge clk);
    data_addr_ok = 1'b0;
    #1;
    chk("rw_wait_data", 32'(data_req), 32'd0);
    chk("rw_stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    rst = 1'b0; mem_reqM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    mem_reqM = 1'b1;
    #1;
    chk("rst_idle_req_stall", 32'(mem_stall), 32'd1);
    chk("rst_idle_no_req", 32'(data_req), 32'd0);
    @(negedge clk);
    mem_reqM = 1'b0;
    #1;
    chk("post_rst_issue", 32'(data_req), 32'd1);
    chk("post_rst_addr", data_addr, 32'h0000_0100);
    chk("post_rst_wstrb", 32'(data_wstrb), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
